def_cmd_sched: RTL and testbench

//  Command scheduler for the two defectoscope control transmitters (dout[1:0]).
//  - Accepts NIOS cmd-bus writes and queues them per channel; broadcast writes go to both channels.
//  - Inserts a periodic poll command on both channels.
//  - Drives each transmitter's valid/ready input handshake.
//  - Sits between nios_sys cmd outputs and the transmitter-side dcfifos; everything is in the clk domain.

---
 rtl/def_cmd_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 74 +++++++
 rtl/def_cmd_sched.sv | 148 ++++++++++++++
 tb/tb_def_cmd_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/def_cmd_pkg.sv
// Shared constants and types for the defectoscope command scheduler.
package def_cmd_pkg;

  localparam logic [7:0] ADDR_CH0   = 8'h00;
  localparam logic [7:0] ADDR_CH1   = 8'h01;
  localparam logic [7:0] ADDR_BCAST = 8'h02;
  localparam logic [7:0] ADDR_CTRL  = 8'h03;

  localparam int CTRL_POLL_EN = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR     = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_CMD  = 2'd1,
    SEND_POLL = 2'd2
  } sched_state_t;

  // Poll word carries the channel index in bit0 so the far end can tell them apart.
  function automatic logic [31:0] poll_word(input logic [31:0] base, input logic ch);
    return (base & ~32'd1) | {31'd0, ch};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with head-of-queue read port and synchronous flush.
module cmd_fifo #(
  parameter int AW = 2,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full/empty are judged on the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/def_cmd_sched.sv
// Command scheduler for the two control transmitters: per-channel queues,
// periodic poll insertion and valid/ready output handshake.
module def_cmd_sched
  import def_cmd_pkg::*;
#(
  parameter int          FIFO_AW  = 2,
  parameter logic [31:0] POLL_DIV = 32'd50000,
  parameter logic [31:0] POLL_CMD = 32'hA5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cmd_wr,
  input  logic [7:0]  i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic [31:0] o_cntr_data0,
  output logic [31:0] o_cntr_data1,
  output logic [1:0]  o_cntr_valid,
  input  logic [1:0]  i_cntr_ready,
  output logic [15:0] o_status,
  output logic        o_irq
);

  logic        wr_ch0, wr_ch1, wr_bcast, wr_ctrl;
  logic        flush, clr_flags;
  logic [1:0]  full, push, ovf_set, poll_take;
  logic [1:0]  ovf_q, ovf_d;
  logic [1:0]  poll_pend_q, poll_pend_d;
  logic        poll_miss_q, poll_miss_d;
  logic        poll_en_q, poll_en_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic        poll_wrap;
  logic [1:0][31:0] data_out;
  logic [1:0][1:0]  cnt_sat;

  // Address decode and queue admission; broadcast is all-or-nothing.
  always_comb begin
    wr_ch0    = i_cmd_wr && (i_cmd_addr == ADDR_CH0);
    wr_ch1    = i_cmd_wr && (i_cmd_addr == ADDR_CH1);
    wr_bcast  = i_cmd_wr && (i_cmd_addr == ADDR_BCAST);
    wr_ctrl   = i_cmd_wr && (i_cmd_addr == ADDR_CTRL);
    flush     = wr_ctrl && i_cmd_data[CTRL_FLUSH];
    clr_flags = wr_ctrl && i_cmd_data[CTRL_CLR];
    push[0]    = (wr_ch0 && !full[0]) || (wr_bcast && (full == 2'b00));
    push[1]    = (wr_ch1 && !full[1]) || (wr_bcast && (full == 2'b00));
    ovf_set[0] = (wr_ch0 || wr_bcast) && full[0];
    ovf_set[1] = (wr_ch1 || wr_bcast) && full[1];
  end

  // Poll timer, pending polls and sticky flags; a new event wins over a clear on the same edge.
  always_comb begin
    poll_wrap   = poll_en_q && (poll_cnt_q == POLL_DIV - 32'd1);
    poll_en_d   = wr_ctrl ? i_cmd_data[CTRL_POLL_EN] : poll_en_q;
    poll_cnt_d  = (!poll_en_q || poll_wrap) ? 32'd0 : poll_cnt_q + 32'd1;
    poll_pend_d = flush ? 2'b00 : (poll_pend_q & ~poll_take);
    if (poll_wrap) poll_pend_d = 2'b11;
    ovf_d       = (clr_flags ? 2'b00 : ovf_q) | ovf_set;
    poll_miss_d = clr_flags ? 1'b0 : poll_miss_q;
    if (poll_wrap && ((poll_pend_q & ~poll_take) != 2'b00)) poll_miss_d = 1'b1;
  end

  // Control/status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q       <= '0;
      poll_pend_q <= '0;
      poll_miss_q <= 1'b0;
      poll_en_q   <= 1'b0;
      poll_cnt_q  <= '0;
    end else begin
      ovf_q       <= ovf_d;
      poll_pend_q <= poll_pend_d;
      poll_miss_q <= poll_miss_d;
      poll_en_q   <= poll_en_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [31:0]      head;
    logic             full_w, empty_w, pop, take;
    logic [FIFO_AW:0] count_w;
    sched_state_t     state_q, state_d;
    logic [31:0]      data_q, data_d;

    cmd_fifo #(.AW(FIFO_AW), .DW(32)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[ch]),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  (i_cmd_data),
      .data_o  (head),
      .full_o  (full_w),
      .empty_o (empty_w),
      .count_o (count_w)
    );

    // Channel FSM: a pending poll beats a queued command; nothing new starts on a flush edge.
    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pop     = 1'b0;
      take    = 1'b0;
      case (state_q)
        IDLE: begin
          if (!flush) begin
            if (poll_pend_q[ch]) begin
              data_d  = poll_word(POLL_CMD, 1'(ch));
              take    = 1'b1;
              state_d = SEND_POLL;
            end else if (!empty_w) begin
              data_d  = head;
              pop     = 1'b1;
              state_d = SEND_CMD;
            end
          end
        end
        SEND_CMD, SEND_POLL: begin
          if (i_cntr_ready[ch]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Channel state and output word registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    assign full[ch]         = full_w;
    assign poll_take[ch]    = take;
    assign data_out[ch]     = data_q;
    assign o_cntr_valid[ch] = (state_q != IDLE);
    assign cnt_sat[ch]      = (count_w > (FIFO_AW+1)'(2)) ? 2'd3 : count_w[1:0];
  end

  assign o_cntr_data0 = data_out[0];
  assign o_cntr_data1 = data_out[1];
  assign o_status     = {8'h00, poll_miss_q, poll_en_q, ovf_q, cnt_sat[1], cnt_sat[0]};
  assign o_irq        = (|ovf_q) | poll_miss_q;

endmodule

// File: tb/tb_def_cmd_sched.sv
// Bench for def_cmd_sched: directed scenarios plus random traffic, checked every
// cycle against a queue-based behavioural model.
module tb_def_cmd_sched;

  localparam logic [31:0] PD   = 32'd8;
  localparam logic [31:0] PCMD = 32'hA5000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cmd_wr;
  logic [7:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic [31:0] o_cntr_data0, o_cntr_data1;
  logic [1:0]  o_cntr_valid;
  logic [1:0]  i_cntr_ready;
  logic [15:0] o_status;
  logic        o_irq;

  int compared   = 0;
  int mismatched = 0;

  def_cmd_sched #(.FIFO_AW(2), .POLL_DIV(PD), .POLL_CMD(PCMD)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cmd_wr     (i_cmd_wr),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_data   (i_cmd_data),
    .o_cntr_data0 (o_cntr_data0),
    .o_cntr_data1 (o_cntr_data1),
    .o_cntr_valid (o_cntr_valid),
    .i_cntr_ready (i_cntr_ready),
    .o_status     (o_status),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] mq   [2][$];
  logic [31:0] mlog [2][$];
  logic [31:0] rec  [2][$];
  bit          m_busy [2];
  logic [31:0] m_cur  [2];
  logic [1:0]  m_pend = '0, m_ovf = '0;
  logic        m_miss = 1'b0, m_pen = 1'b0;
  int          m_pcnt = 0;
  logic [1:0]  s_full, s_taken;
  logic        s_w0, s_w1, s_bc, s_ctrl, s_flush, s_clr, s_wrap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        mq[c].delete();
        m_busy[c] = 0;
        m_cur[c]  = '0;
      end
      m_pend = '0; m_ovf = '0; m_miss = 0; m_pen = 0; m_pcnt = 0;
    end else begin
      for (int c = 0; c < 2; c++)
        if (o_cntr_valid[c] && i_cntr_ready[c])
          rec[c].push_back(c == 0 ? o_cntr_data0 : o_cntr_data1);
      s_full[0] = (mq[0].size() == 4);
      s_full[1] = (mq[1].size() == 4);
      s_w0   = i_cmd_wr && i_cmd_addr == 8'h00;
      s_w1   = i_cmd_wr && i_cmd_addr == 8'h01;
      s_bc   = i_cmd_wr && i_cmd_addr == 8'h02;
      s_ctrl = i_cmd_wr && i_cmd_addr == 8'h03;
      s_flush = s_ctrl && i_cmd_data[1];
      s_clr   = s_ctrl && i_cmd_data[2];
      s_wrap  = m_pen && (m_pcnt == int'(PD) - 1);
      for (int c = 0; c < 2; c++) begin
        s_taken[c] = 1'b0;
        if (m_busy[c]) begin
          if (i_cntr_ready[c]) m_busy[c] = 0;
        end else if (!s_flush) begin
          if (m_pend[c]) begin
            m_cur[c] = (PCMD & ~32'd1) | 32'(c);
            m_busy[c] = 1; s_taken[c] = 1'b1;
            mlog[c].push_back(m_cur[c]);
          end else if (mq[c].size() != 0) begin
            m_cur[c] = mq[c].pop_front();
            m_busy[c] = 1;
            mlog[c].push_back(m_cur[c]);
          end
        end
      end
      if (s_clr) begin m_ovf = 2'b00; m_miss = 1'b0; end
      if (s_w0) begin if (s_full[0]) m_ovf[0] = 1'b1; else mq[0].push_back(i_cmd_data); end
      if (s_w1) begin if (s_full[1]) m_ovf[1] = 1'b1; else mq[1].push_back(i_cmd_data); end
      if (s_bc) begin
        if (s_full == 2'b00) begin mq[0].push_back(i_cmd_data); mq[1].push_back(i_cmd_data); end
        else m_ovf = m_ovf | s_full;
      end
      if (s_flush) begin mq[0].delete(); mq[1].delete(); end
      if (s_wrap && ((m_pend & ~s_taken) != 2'b00)) m_miss = 1'b1;
      m_pend = s_flush ? 2'b00 : (m_pend & ~s_taken);
      if (s_wrap) m_pend = 2'b11;
      m_pcnt = (!m_pen || s_wrap) ? 0 : m_pcnt + 1;
      if (s_ctrl) m_pen = i_cmd_data[0];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat(input int n);
    return (n >= 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic cmp_all();
    check("valid", 32'(o_cntr_valid), 32'({m_busy[1], m_busy[0]}));
    if (m_busy[0]) check("data0", o_cntr_data0, m_cur[0]);
    if (m_busy[1]) check("data1", o_cntr_data1, m_cur[1]);
    check("status", 32'(o_status),
          32'({8'h00, m_miss, m_pen, m_ovf, sat(mq[1].size()), sat(mq[0].size())}));
    check("irq", 32'(o_irq), 32'((|m_ovf) | m_miss));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_cmd(input logic [7:0] a, input logic [31:0] d);
    i_cmd_wr = 1'b1; i_cmd_addr = a; i_cmd_data = d;
    tick();
    i_cmd_wr = 1'b0;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < 2; c++) begin rec[c].delete(); mlog[c].delete(); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int polls;
  int sel;

  initial begin
    reset = 1'b1; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_data = '0; i_cntr_ready = 2'b00;
    ticks(2);
    check("rst_valid", 32'(o_cntr_valid), 32'd0);
    check("rst_status", 32'(o_status), 32'd0);
    check("rst_irq", 32'(o_irq), 32'd0);
    check("rst_data0", o_cntr_data0, 32'd0);
    reset = 1'b0;
    ticks(2);

    // T1: single command, two-edge latency, one beat
    i_cntr_ready = 2'b01;
    wr_cmd(8'h00, 32'h11223344);
    check("t1_lat_edge1", 32'(o_cntr_valid), 32'd0);
    tick();
    check("t1_valid", 32'(o_cntr_valid), 32'b01);
    check("t1_data", o_cntr_data0, 32'h11223344);
    tick();
    check("t1_one_beat", 32'(o_cntr_valid), 32'd0);

    // T2: overflow on ch0, then in-order drain and flag clear
    clear_logs();
    i_cntr_ready = 2'b00;
    for (int i = 0; i < 6; i++) wr_cmd(8'h00, 32'h200 + 32'(i));
    check("t2_ovf", 32'(o_status[5:4]), 32'b01);
    check("t2_irq", 32'(o_irq), 32'd1);
    check("t2_cnt0", 32'(o_status[1:0]), 32'd3);
    check("t2_head", o_cntr_data0, 32'h200);
    i_cntr_ready = 2'b01;
    ticks(12);
    check("t2_drained", 32'(rec[0].size()), 32'd5);
    for (int i = 0; i < rec[0].size(); i++) check("t2_order", rec[0][i], 32'h200 + 32'(i));
    wr_cmd(8'h03, 32'h4);
    check("t2_irq_clr", 32'(o_irq), 32'd0);

    // T3: broadcast refused while ch1 full, accepted when both free
    i_cntr_ready = 2'b00;
    for (int i = 0; i < 5; i++) wr_cmd(8'h01, 32'h300 + 32'(i));
    wr_cmd(8'h02, 32'hCAFE0000);
    check("t3_ovf", 32'(o_status[5:4]), 32'b10);
    check("t3_cnt0", 32'(o_status[1:0]), 32'd0);
    check("t3_valid0", 32'(o_cntr_valid[0]), 32'd0);
    wr_cmd(8'h03, 32'h4);
    i_cntr_ready = 2'b11;
    ticks(12);
    check("t3_idle", 32'(o_cntr_valid), 32'd0);
    clear_logs();
    wr_cmd(8'h02, 32'hCAFE0000);
    ticks(4);
    check("t3_bc_n0", 32'(rec[0].size()), 32'd1);
    check("t3_bc_n1", 32'(rec[1].size()), 32'd1);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < rec[c].size(); i++) check("t3_bc_word", rec[c][i], 32'hCAFE0000);

    // T4: polls every PD clocks, ahead of queued commands
    clear_logs();
    i_cntr_ready = 2'b10;
    wr_cmd(8'h03, 32'h1);
    for (int i = 0; i < 4; i++) wr_cmd(8'h00, 32'h400 + 32'(i));
    ticks(4);
    i_cntr_ready = 2'b11;
    ticks(56);
    polls = 0;
    foreach (rec[1][i]) if (rec[1][i] == 32'hA5000001) polls++;
    check("t4_polls_ch1", 32'(polls), 32'd7);
    check("t4_ch1_only_polls", 32'(rec[1].size()), 32'd7);
    check("t4_ch0_first", rec[0].size() > 0 ? rec[0][0] : 32'hDEAD, 32'h400);
    check("t4_ch0_poll_first", rec[0].size() > 1 ? rec[0][1] : 32'hDEAD, 32'hA5000000);
    i_cntr_ready = 2'b00;
    ticks(30);
    check("t4_miss", 32'(o_status[7]), 32'd1);
    check("t4_miss_irq", 32'(o_irq), 32'd1);
    wr_cmd(8'h03, 32'h0);
    wr_cmd(8'h03, 32'h6);
    check("t4_miss_clr", 32'(o_status[7:6]), 32'd0);
    check("t4_irq_clr", 32'(o_irq), 32'd0);
    i_cntr_ready = 2'b11;
    ticks(6);
    check("t4_idle", 32'(o_cntr_valid), 32'd0);

    // T5: flush keeps the in-flight word, reset drops valid at once
    i_cntr_ready = 2'b00;
    for (int i = 0; i < 3; i++) wr_cmd(8'h00, 32'h500 + 32'(i));
    check("t5_cnt_pre", 32'(o_status[1:0]), 32'd2);
    wr_cmd(8'h03, 32'h2);
    check("t5_cnt_flush", 32'(o_status[1:0]), 32'd0);
    ticks(3);
    check("t5_held_valid", 32'(o_cntr_valid), 32'b01);
    check("t5_held_data", o_cntr_data0, 32'h500);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(o_cntr_valid), 32'd0);
    check("t5_rst_status", 32'(o_status), 32'd0);
    tick();
    reset = 1'b0;
    ticks(2);

    // T6: random traffic on both channels
    clear_logs();
    for (int n = 0; n < 400; n++) begin
      i_cmd_wr     = 1'($urandom_range(0, 1));
      sel          = int'($urandom_range(0, 3));
      i_cmd_addr   = (sel == 3) ? 8'h09 : 8'(sel);
      i_cmd_data   = $urandom;
      i_cntr_ready = 2'($urandom_range(0, 3));
      tick();
    end
    i_cmd_wr = 1'b0;
    i_cntr_ready = 2'b11;
    ticks(24);
    check("t6_idle", 32'(o_cntr_valid), 32'd0);
    check("t6_empty", 32'(o_status[3:0]), 32'd0);
    for (int c = 0; c < 2; c++) begin
      check("t6_count", 32'(rec[c].size()), 32'(mlog[c].size()));
      for (int i = 0; i < rec[c].size() && i < mlog[c].size(); i++)
        check("t6_word", rec[c][i], mlog[c][i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
